// File: rtl/boot_sequencer_if.sv
// Byte-stream loader and instruction-memory write port of the boot sequencer.
//
// Handshake: a byte moves on a rising clk edge exactly when rx_valid and
// rx_ready are both high in the cycle before that edge. The producer holds
// rx_data stable while rx_valid is high. rx_valid may rise or fall at any
// time, and nothing is consumed while rx_ready is low. imem_we is a one-cycle
// strobe that carries imem_waddr and imem_wdata; the memory has no ready.
interface boot_sequencer_if #(
   parameter int ADDR_W = 10
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [31:0]       imem_wdata;

   // host / loader side
   modport master (
      output rx_valid, rx_data,
      input  rx_ready, imem_we, imem_waddr, imem_wdata
   );

   // boot sequencer side
   modport slave (
      input  rx_valid, rx_data,
      output rx_ready, imem_we, imem_waddr, imem_wdata
   );
endinterface

// File: rtl/boot_sequencer.sv
// Boot and run controller. It takes a length-prefixed little-endian program
// image from a byte stream and writes it word by word into IMEM while holding
// the core in reset. It then releases the core and counts run cycles until
// the core halts or the cycle limit is reached.
module boot_sequencer #(
   parameter int IMEM_DEPTH = 1024,
   parameter int ADDR_W     = 10,
   parameter int MAX_CYCLES = 100000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   boot_sequencer_if.slave     bus,
   output logic                core_rst_n,
   input  logic                core_halt,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [1:0]          err_code,
   output logic [31:0]         cycle_count,
   output logic [2:0]          dbg_state
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      LOAD = 3'd2,
      RUN  = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } state_t;

   state_t state, next_state;

   logic [1:0]  byte_cnt;   // byte position inside the current 32-bit word
   logic [31:0] asm_q;      // word being assembled (header or data)
   logic [31:0] len_q;      // word count N taken from the header
   logic [31:0] word_idx;   // index of the next IMEM word to write
   logic        wr_pend;    // a complete word waits to be written next edge

   logic        accept;
   logic        last_byte;
   logic        last_word;
   logic [31:0] hdr_word;
   logic        len_bad;
   logic        run_live;
   logic        count_en;
   logic        start_ok;
   logic        at_limit;

   logic        rx_ready_nxt;
   logic        core_rst_n_nxt;
   logic        busy_nxt;
   logic        done_nxt;
   logic        err_nxt;

   assign accept    = bus.rx_valid && bus.rx_ready;
   assign last_byte = (byte_cnt == 2'd3);
   assign last_word = (word_idx == (len_q - 32'd1));
   assign hdr_word  = {bus.rx_data, asm_q[23:0]};
   assign len_bad   = (hdr_word == 32'd0) || (hdr_word > 32'(IMEM_DEPTH));
   assign run_live  = (state == RUN) && core_rst_n;
   assign count_en  = run_live && !core_halt;
   assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
   assign at_limit  = (cycle_count == 32'(MAX_CYCLES - 1));
   assign dbg_state = state;

   // State register; reset wins over everything, including start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) next_state = HDR;
         end
         HDR: begin
            if (accept && last_byte) next_state = len_bad ? ERR : LOAD;
         end
         LOAD: begin
            // Leave only once the final word's write is being issued, so IMEM
            // is complete before the core comes out of reset.
            if (wr_pend && last_word) next_state = RUN;
         end
         RUN: begin
            if (run_live && core_halt)              next_state = DONE;
            else if (count_en && at_limit)          next_state = ERR;
         end
         DONE: begin
            if (start) next_state = HDR;
         end
         ERR: begin
            if (start) next_state = HDR;
         end
         default: next_state = IDLE;
      endcase
   end

   // Next values of the registered control outputs.
   always_comb begin
      rx_ready_nxt   = 1'b0;
      core_rst_n_nxt = 1'b0;
      busy_nxt       = 1'b0;
      done_nxt       = 1'b0;
      err_nxt        = 1'b0;
      // Stop accepting right after the final data byte; the cycle that follows
      // only issues the last write.
      if (next_state == HDR) begin
         rx_ready_nxt = 1'b1;
      end else if (next_state == LOAD) begin
         rx_ready_nxt = !((state == LOAD) && accept && last_byte && last_word);
      end
      // The core leaves reset one cycle after RUN is entered and stays out of
      // reset in DONE so its halted state can be inspected.
      core_rst_n_nxt = ((state == RUN) && ((next_state == RUN) || (next_state == DONE))) ||
                       ((state == DONE) && (next_state == DONE));
      busy_nxt = (next_state == HDR) || (next_state == LOAD) || (next_state == RUN);
      done_nxt = (state == DONE) && (next_state == DONE);
      err_nxt  = (next_state == ERR);
   end

   // Registered outputs, byte assembly, IMEM writes and the run-cycle counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.rx_ready   <= 1'b0;
         bus.imem_we    <= 1'b0;
         bus.imem_waddr <= '0;
         bus.imem_wdata <= '0;
         core_rst_n     <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         err_code       <= 2'b00;
         cycle_count    <= '0;
         byte_cnt       <= 2'd0;
         asm_q          <= '0;
         len_q          <= '0;
         word_idx       <= '0;
         wr_pend        <= 1'b0;
      end else begin
         bus.rx_ready <= rx_ready_nxt;
         core_rst_n   <= core_rst_n_nxt;
         busy         <= busy_nxt;
         done         <= done_nxt;
         err          <= err_nxt;
         bus.imem_we  <= 1'b0;

         if (start_ok) begin
            byte_cnt    <= 2'd0;
            word_idx    <= '0;
            cycle_count <= '0;
            err_code    <= 2'b00;
            wr_pend     <= 1'b0;
         end

         if ((state == HDR) && accept) begin
            asm_q[{byte_cnt, 3'b000} +: 8] <= bus.rx_data;
            byte_cnt                       <= byte_cnt + 2'd1;
            if (last_byte) begin
               len_q <= hdr_word;
               if (len_bad) err_code <= 2'b01;
            end
         end

         if ((state == LOAD) && wr_pend) begin
            bus.imem_we    <= 1'b1;
            bus.imem_waddr <= word_idx[ADDR_W-1:0];
            bus.imem_wdata <= asm_q;
            word_idx       <= word_idx + 32'd1;
            wr_pend        <= 1'b0;
         end

         if ((state == LOAD) && accept) begin
            asm_q[{byte_cnt, 3'b000} +: 8] <= bus.rx_data;
            byte_cnt                       <= byte_cnt + 2'd1;
            if (last_byte) wr_pend <= 1'b1;
         end

         if (count_en && (cycle_count != 32'(MAX_CYCLES))) begin
            cycle_count <= cycle_count + 32'd1;
         end

         if ((state == RUN) && (next_state == ERR)) begin
            err_code <= 2'b10;
         end
      end
   end

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: loads, header errors, halt, timeout,
// stalled streams and reset during a load.
module tb_boot_sequencer;

   localparam int IMEM_DEPTH = 1024;
   localparam int ADDR_W     = 10;
   localparam int MAX_CYCLES = 50;
   localparam int W          = ADDR_W + 32;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_HDR  = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        core_halt;
   logic        core_rst_n;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [31:0] cycle_count;
   logic [2:0]  dbg_state;

   boot_sequencer_if #(.ADDR_W(ADDR_W)) bus_if ();

   boot_sequencer #(
      .IMEM_DEPTH (IMEM_DEPTH),
      .ADDR_W     (ADDR_W),
      .MAX_CYCLES (MAX_CYCLES)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .bus         (bus_if.slave),
      .core_rst_n  (core_rst_n),
      .core_halt   (core_halt),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .err_code    (err_code),
      .cycle_count (cycle_count),
      .dbg_state   (dbg_state)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [W-1:0]  exp_q[$];
   logic [31:0]   img[0:7];

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // scoreboard: every IMEM write must match the head of exp_q
   always @(negedge clk) begin
      if (bus_if.imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_write", {22'd0, bus_if.imem_waddr, bus_if.imem_wdata}, 64'd0);
         end else begin
            check_eq("imem_write", {22'd0, bus_if.imem_waddr, bus_if.imem_wdata},
                     {22'd0, exp_q.pop_front()});
         end
      end
   end

   // driver tasks
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n;
      if (gaps) begin
         n = 0;
         while (($urandom_range(0, 1) == 1) && (n < 8)) begin
            tick(1);
            n++;
         end
      end
      bus_if.rx_valid = 1'b1;
      bus_if.rx_data  = b;
      n = 0;
      while ((bus_if.rx_ready !== 1'b1) && (n < 100)) begin
         tick(1);
         n++;
      end
      check_eq("rx_accept_in_time", {63'd0, (n < 100)}, 64'd1);
      if (n < 100) tick(1);
      bus_if.rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
   endtask

   task automatic load_image(input int n, input bit gaps);
      send_word(32'(n), gaps);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({ADDR_W'(i), img[i]});
         send_word(img[i], gaps);
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_state"},      {61'd0, dbg_state}, {61'd0, S_IDLE});
      check_eq({pfx, "_rx_ready"},   {63'd0, bus_if.rx_ready}, 64'd0);
      check_eq({pfx, "_imem_we"},    {63'd0, bus_if.imem_we}, 64'd0);
      check_eq({pfx, "_imem_waddr"}, {54'd0, bus_if.imem_waddr}, 64'd0);
      check_eq({pfx, "_imem_wdata"}, {32'd0, bus_if.imem_wdata}, 64'd0);
      check_eq({pfx, "_core_rst_n"}, {63'd0, core_rst_n}, 64'd0);
      check_eq({pfx, "_busy"},       {63'd0, busy}, 64'd0);
      check_eq({pfx, "_done"},       {63'd0, done}, 64'd0);
      check_eq({pfx, "_err"},        {63'd0, err}, 64'd0);
      check_eq({pfx, "_err_code"},   {62'd0, err_code}, 64'd0);
      check_eq({pfx, "_cycle_count"}, {32'd0, cycle_count}, 64'd0);
   endtask

   initial begin
      rst_n           = 1'b0;
      start           = 1'b0;
      core_halt       = 1'b0;
      bus_if.rx_valid = 1'b0;
      bus_if.rx_data  = 8'h00;
      tick(3);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick(1);

      // N=3 gap-free load; core released two edges after the last byte
      img[0] = 32'h00500093;
      img[1] = 32'h00100073;
      img[2] = 32'h00000013;
      do_start();
      check_eq("start_rx_ready", {63'd0, bus_if.rx_ready}, 64'd1);
      check_eq("start_busy", {63'd0, busy}, 64'd1);
      check_eq("start_state", {61'd0, dbg_state}, {61'd0, S_HDR});
      load_image(3, 1'b0);
      check_eq("t_core_rst_n", {63'd0, core_rst_n}, 64'd0);
      check_eq("t_rx_ready", {63'd0, bus_if.rx_ready}, 64'd0);
      tick(1);
      check_eq("t1_state_run", {61'd0, dbg_state}, {61'd0, S_RUN});
      check_eq("t1_final_we", {63'd0, bus_if.imem_we}, 64'd1);
      check_eq("t1_core_rst_n", {63'd0, core_rst_n}, 64'd0);
      tick(1);
      check_eq("t2_core_rst_n", {63'd0, core_rst_n}, 64'd1);
      check_eq("load3_all_written", 64'(exp_q.size()), 64'd0);

      // halt after 10 counted cycles
      tick(10);
      check_eq("run10_count", {32'd0, cycle_count}, 64'd10);
      check_eq("run10_busy", {63'd0, busy}, 64'd1);
      core_halt = 1'b1;
      tick(1);
      check_eq("halt_state", {61'd0, dbg_state}, {61'd0, S_DONE});
      check_eq("halt_count", {32'd0, cycle_count}, 64'd10);
      tick(1);
      check_eq("halt_done", {63'd0, done}, 64'd1);
      check_eq("halt_core_rst_n", {63'd0, core_rst_n}, 64'd1);
      check_eq("halt_busy", {63'd0, busy}, 64'd0);
      tick(3);
      check_eq("done_count_frozen", {32'd0, cycle_count}, 64'd10);
      core_halt = 1'b0;

      // restart from DONE, then run into the cycle limit
      img[0] = 32'h00000013;
      do_start();
      check_eq("restart_core_rst_n", {63'd0, core_rst_n}, 64'd0);
      check_eq("restart_done", {63'd0, done}, 64'd0);
      check_eq("restart_count", {32'd0, cycle_count}, 64'd0);
      load_image(1, 1'b0);
      tick(2);
      check_eq("to_core_rst_n", {63'd0, core_rst_n}, 64'd1);
      tick(MAX_CYCLES - 1);
      check_eq("to_pre_count", {32'd0, cycle_count}, 64'(MAX_CYCLES - 1));
      check_eq("to_pre_err", {63'd0, err}, 64'd0);
      tick(1);
      check_eq("to_err", {63'd0, err}, 64'd1);
      check_eq("to_err_code", {62'd0, err_code}, 64'd2);
      check_eq("to_count", {32'd0, cycle_count}, 64'(MAX_CYCLES));
      check_eq("to_core_rst_n_low", {63'd0, core_rst_n}, 64'd0);
      check_eq("to_state", {61'd0, dbg_state}, {61'd0, S_ERR});

      // bad header lengths
      do_start();
      check_eq("err_cleared", {63'd0, err}, 64'd0);
      check_eq("err_code_cleared", {62'd0, err_code}, 64'd0);
      send_word(32'd0, 1'b0);
      check_eq("len0_err", {63'd0, err}, 64'd1);
      check_eq("len0_code", {62'd0, err_code}, 64'd1);
      check_eq("len0_rx_ready", {63'd0, bus_if.rx_ready}, 64'd0);
      do_start();
      send_word(32'(IMEM_DEPTH + 1), 1'b0);
      check_eq("len_big_err", {63'd0, err}, 64'd1);
      check_eq("len_big_code", {62'd0, err_code}, 64'd1);
      check_eq("len_big_state", {61'd0, dbg_state}, {61'd0, S_ERR});
      img[0] = 32'hdeadbeef;
      do_start();
      check_eq("n1_err_cleared", {63'd0, err}, 64'd0);
      load_image(1, 1'b0);
      tick(2);
      check_eq("n1_core_rst_n", {63'd0, core_rst_n}, 64'd1);

      // reset and start in the same cycle: reset wins
      rst_n = 1'b0;
      start = 1'b1;
      tick(1);
      check_eq("rst_start_state", {61'd0, dbg_state}, {61'd0, S_IDLE});
      check_eq("rst_start_core_rst_n", {63'd0, core_rst_n}, 64'd0);
      check_eq("rst_start_busy", {63'd0, busy}, 64'd0);
      rst_n = 1'b1;
      start = 1'b0;
      tick(1);

      // N=4 with random rx_valid gaps
      img[0] = 32'h12345678;
      img[1] = 32'h9abcdef0;
      img[2] = 32'h0f1e2d3c;
      img[3] = 32'hffffffff;
      do_start();
      load_image(4, 1'b1);
      tick(1);
      check_eq("gap_state_run", {61'd0, dbg_state}, {61'd0, S_RUN});
      tick(1);
      check_eq("gap_core_rst_n", {63'd0, core_rst_n}, 64'd1);
      check_eq("gap_all_written", 64'(exp_q.size()), 64'd0);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);

      // reset mid-LOAD after 6 bytes, then a clean reload
      do_start();
      send_word(32'd2, 1'b0);
      send_byte(8'haa, 1'b0);
      send_byte(8'hbb, 1'b0);
      rst_n = 1'b0;
      tick(1);
      check_reset_outputs("midload");
      rst_n = 1'b1;
      tick(1);
      img[0] = 32'h11223344;
      img[1] = 32'h55667788;
      do_start();
      load_image(2, 1'b0);
      tick(2);
      check_eq("reload_core_rst_n", {63'd0, core_rst_n}, 64'd1);
      tick(2);
      check_eq("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/boot_sequencer.md
# boot_sequencer

Boot and run controller for the single-cycle RISC-V core. It receives a program image as a byte stream with a valid/ready handshake and writes it word-by-word into the instruction memory write port. It holds the core in reset during the load, then releases it and counts cycles until the core raises halt or a timeout expires. It sits between the testbench/host loader and the `RISCV_Single_Cycle` top, gating the core's `rst_n`.

## Interface
Parameters:
- IMEM_DEPTH, 1024, instruction memory size in 32-bit words
- ADDR_W, 10, word-address width; IMEM_DEPTH ≤ 2^ADDR_W
- MAX_CYCLES, 100000, run-cycle limit before timeout; must be ≥ 1

Ports:
- Reset is synchronous and active-low (`rst_n`); one clock (`clk`).
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a load; sampled only in IDLE, DONE or ERR
- rx_valid  in  1  byte available
- rx_data  in  8  stream byte
- rx_ready  out  1  byte accepted when rx_valid && rx_ready
- imem_we  out  1  IMEM write strobe, one-cycle pulse per word
- imem_waddr  out  ADDR_W  IMEM word address
- imem_wdata  out  32  IMEM write data
- core_rst_n  out  1  drives core `rst_n`; 0 holds the core in reset
- core_halt  in  1  core halt indication
- busy  out  1  state is HDR, LOAD or RUN
- done  out  1  halt observed
- err  out  1  error state
- err_code  out  2  00 none, 01 bad length, 10 timeout, 11 reserved
- cycle_count  out  32  run cycles counted

## Operation
- States: IDLE, HDR, LOAD, RUN, DONE, ERR. The state register and all outputs are registered.
- IDLE:
  - rx_ready=0, core_rst_n=0.
  - start=1 → HDR. Clear the byte counter, word index, cycle_count, done, err and err_code.
- HDR:
  - rx_ready=1.
  - Accept 4 bytes, little-endian, into a 32-bit word count N.
  - On the 4th accepted byte: if N==0 or N>IMEM_DEPTH → ERR with err_code=01; otherwise → LOAD.
- LOAD:
  - rx_ready=1.
  - Accept bytes little-endian: byte k of a word goes to bits [8k+7:8k].
  - On the 4th byte of word i, the next edge sets imem_we=1, imem_waddr=i[ADDR_W-1:0], imem_wdata=assembled word. imem_we is low in every other cycle.
  - After word N-1 is accepted → RUN (the same edge issues the final write).
- RUN:
  - rx_ready=0. core_rst_n=1, registered from the state, so it rises one cycle after entering RUN.
  - cycle_count increments by 1 every cycle in which core_rst_n=1 and core_halt=0.
  - core_halt=1 while core_rst_n=1 → DONE; that cycle is not counted.
  - cycle_count==MAX_CYCLES-1 while incrementing → ERR with err_code=10. cycle_count saturates at MAX_CYCLES.
- DONE:
  - done=1. core_rst_n stays 1 so the halted core's PC and registers remain observable.
  - cycle_count is frozen.
  - start → HDR: core_rst_n=0 and done/cycle_count clear.
- ERR:
  - err=1, core_rst_n=0, err_code held.
  - start → HDR: clears err and err_code.
- Ignored inputs:
  - start is ignored in HDR, LOAD and RUN.
  - rx_valid is ignored when rx_ready=0; no byte is consumed.
  - core_halt is ignored unless in RUN with core_rst_n=1.
- Words beyond N are never written. IMEM contents outside 0..N-1 are untouched.

## Timing
- Reset values:
  - state=IDLE.
  - rx_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0.
  - core_rst_n=0, busy=0, done=0, err=0, err_code=00, cycle_count=0.
- Reset mid-operation (any state) returns to IDLE next edge with the reset values; a partial load is discarded and core_rst_n=0.
- start→HDR: 1 cycle. rx_ready=1 in the first HDR cycle.
- Throughput: 1 byte per cycle with rx_valid held high. A write lands 1 cycle after its 4th byte.
- Gaps: rx_valid low stalls the byte counter; no timeout applies in HDR or LOAD.
- Last byte accepted at edge T:
  - edge T+1: final imem_we pulse and state=RUN.
  - edge T+2: core_rst_n=1.
  - This guarantees IMEM is fully written before the core's first fetch.
- Halt: core_halt high at edge H → done=1 after edge H+1; cycle_count holds its value from before H.
- start and rst_n both active in the same cycle: reset wins.

## Test plan
- Load N=3 words (0x00500093, 0x00100073, 0x00000013) at 1 byte/cycle → three imem_we pulses at addr 0, 1, 2 with exact data; core_rst_n rises 2 cycles after the 16th byte (4 header bytes + 12 data bytes).
- Header N=0 → ERR, err_code=01, no imem_we. Header N=IMEM_DEPTH+1 → ERR, err_code=01. Then start with N=1 → loads normally with err cleared.
- RUN with core_halt asserted 10 cycles after core_rst_n rises → DONE, done=1, cycle_count=10, core_rst_n stays 1.
- MAX_CYCLES=50 with core_halt held 0 → ERR, err_code=10, cycle_count=50, core_rst_n=0.
- Random rx_valid gaps (50% duty) for N=4 → identical IMEM writes to the gap-free case; no byte is lost or duplicated.
- rst_n low mid-LOAD (after 6 bytes) → IDLE next edge with all outputs at reset values; a subsequent start reloads from the header.
